// File: rtl/ascon_round_controller.sv
// Round sequencer for the Ascon permutation: runs p^a or p^b, UNROLL rounds per clock,
// and drives per-lane round constants and enables into the unrolled round datapath.
module ascon_round_controller #(
    parameter int unsigned UNROLL   = 1,
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [UNROLL-1:0]     lane_en,
    output logic [8*UNROLL-1:0]   rc,
    output logic [3:0]            round_idx,
    output logic [4:0]            counter
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [4:0]  counter_nx;
    logic [4:0]  idx_step;
    logic [4:0]  lane_i;
    logic [4:0]  en_count;
    logic [3:0]  start_idx;
    logic        accept;

    // Ascon p^R uses the last R of the 12 round constants, so a run starts at 12-R.
    assign start_idx = mode ? 4'(12 - ROUNDS_B) : 4'(12 - ROUNDS_A);
    assign accept    = start && !abort;
    assign idx_step  = {1'b0, idx} + 5'(UNROLL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            counter <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            counter <= counter_nx;
        end
    end

    always_comb begin
        lane_en   = '0;
        rc        = '0;
        round_idx = '0;
        en_count  = '0;
        lane_i    = '0;
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        if (state == S_RUN) begin
            round_idx = idx;
            for (int unsigned k = 0; k < UNROLL; k++) begin
                lane_i = {1'b0, idx} + 5'(k);
                if (lane_i < 5'd12) begin
                    lane_en[k]    = 1'b1;
                    rc[8*k +: 8]  = {~lane_i[3:0], lane_i[3:0]};
                    en_count      = en_count + 5'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        counter_nx = counter;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nx   = S_RUN;
                    idx_nx     = start_idx;
                    counter_nx = '0;
                end else begin
                    state_nx   = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx   = S_IDLE;
                    idx_nx     = '0;
                    counter_nx = '0;
                end else begin
                    counter_nx = counter + en_count;
                    if (idx_step >= 5'd12) begin
                        state_nx = S_DONE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx   = idx_step[3:0];
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ascon_round_controller.md
# ascon_round_controller

Parametrised round sequencer for the Ascon permutation datapath, the next-generation replacement for the single-rate round counter. It runs either p^a (ROUNDS_A rounds) or p^b (ROUNDS_B rounds) on request and processes UNROLL rounds per clock. Each cycle it supplies the Ascon round constants and per-lane enables to the unrolled round logic. It also provides a start/busy/done handshake and abort to the mode FSM.

## Interface
- UNROLL, 1: rounds evaluated per clock; legal values 1..4.
- ROUNDS_A, 12: round count for p^a; legal values 1..12.
- ROUNDS_B, 6: round count for p^b; legal values 1..ROUNDS_A.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a permutation; sampled each cycle.
- mode  input  1  0 = p^a, 1 = p^b; sampled together with accepted start.
- abort  input  1  cancel the run in progress.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the last round cycle.
- lane_en  output  UNROLL  lane k applies a round this cycle.
- rc  output  8*UNROLL  round constant for lane k in bits [8k+7:8k].
- round_idx  output  4  absolute Ascon round index of lane 0.
- counter  output  5  rounds completed in the current or last run.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE and clears all registers.
- R = mode ? ROUNDS_B : ROUNDS_A. Internal index idx (4 bits) is the absolute round number of lane 0.
- IDLE:
  - start=1 and abort=0: load idx = 12-R, clear counter, latch mode, go to RUN.
- RUN:
  - busy=1.
  - Lane k has i = idx+k, computed 5 bits wide. lane_en[k] = (i < 12).
  - rc lane k = {~i[3:0], i[3:0]} when enabled, else 8'h00. Examples: i=0 gives F0, i=6 gives 96, i=11 gives 4B.
  - round_idx = idx.
  - Each cycle, counter += popcount(lane_en) and idx += UNROLL.
  - If idx+UNROLL >= 12, go to DONE; otherwise stay in RUN.
  - abort=1: go to IDLE, clear counter and idx. No done pulse. Lane outputs for that cycle are still driven.
  - start during RUN is ignored.
- DONE:
  - done=1 and busy=0. counter holds R.
  - start=1 (abort=0) is accepted exactly as in IDLE and goes to RUN. Otherwise go to IDLE.
- Outside RUN: lane_en=0, rc=0, round_idx=0.
- counter holds its value in IDLE until the next accepted start.
- abort outside RUN has no effect except to block a simultaneous start. abort always wins over start.

## Timing
- Reset values: busy=0, done=0, lane_en=0, rc=0, round_idx=0, counter=0.
- Reset assertion takes effect immediately, even mid-run. Release is synchronous to the next clk edge.
- Start accepted at edge T: RUN cycles are T+1 .. T+N, where N = ceil(R/UNROLL).
  - done is high during cycle T+N+1.
  - Start-to-done latency is N+1 cycles.
- Back-to-back runs: start held during DONE gives the next RUN on the following cycle. Throughput is one run per N+1 cycles.
- All outputs are registered state or purely combinational from state. There is no combinational path from any input to any output.
- counter width: maximum value 12, no wrap-around. The idx adder is 5 bits wide so that idx+UNROLL cannot overflow.

## Test plan
- UNROLL=1, mode=0, single start pulse:
  - busy high for 12 cycles.
  - rc sequence F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - done pulse on cycle 13 after start; counter=12.
- UNROLL=1, mode=1 (ROUNDS_B=6):
  - 6 RUN cycles, first rc=96, last rc=4B.
  - round_idx runs 6..11; done on cycle 7; counter=6.
- UNROLL=4, ROUNDS_B=6, mode=1:
  - Cycle 1: lane_en=1111, rc lanes 96,87,78,69, round_idx=6.
  - Cycle 2: lane_en=0011, rc lanes 5A,4B,00,00, round_idx=10.
  - done on cycle 3; counter=6.
- Abort in the 5th RUN cycle of a 12-round run:
  - Next cycle IDLE, no done pulse, counter=0.
  - start and abort together in IDLE: start ignored, stays IDLE.
- Start held high through DONE:
  - The second run begins the cycle after done.
  - Second run's rc restarts at F0; counter cleared to 0 then counts to 12 again.
- rst driven low asynchronously mid-RUN, between clock edges:
  - All outputs drop to their reset values before the next edge.
  - After release, IDLE until a new start.
